// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS subsystem: measurement FSM states and
// default measurement-window parameters also used by tuning-word calculations.
package dds_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      GATE = 2'd2,
      DONE = 2'd3
   } meas_state_e;

   localparam int unsigned DDS_GATE_CYCLES = 1_000_000;
   localparam int unsigned DDS_ARM_TIMEOUT = 2_000_000;
   localparam int unsigned DDS_CNT_W       = 32;

   // Timer only ever holds values up to max(gate, timeout) - 1.
   function automatic int unsigned timer_width(input int unsigned gate_cycles,
                                                input int unsigned arm_timeout);
      int unsigned span;
      span = (gate_cycles > arm_timeout) ? gate_cycles : arm_timeout;
      return (span < 32'd2) ? 32'd1 : $clog2(span);
   endfunction

endpackage

// File: rtl/dds_sync_edge.sv
// Two-flop synchronizer plus history flop producing a clean level and a
// one-cycle rising-edge strobe from an asynchronous input.
module dds_sync_edge
   import dds_pkg::*;
(
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic hist_q;
   logic meta_d;
   logic sync_d;
   logic hist_d;

   // next-state of the synchronizer chain
   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
      hist_d = sync_q;
   end

   // synchronizer and history registers
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~hist_q;

endmodule

// File: rtl/dds_freq_meter.sv
// Gated edge-counting frequency/duty meter: arms on the first rising edge of
// f_in_i, then counts rising edges and high cycles over a fixed window.
module dds_freq_meter
   import dds_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = DDS_GATE_CYCLES,
   parameter int unsigned ARM_TIMEOUT = DDS_ARM_TIMEOUT,
   parameter int unsigned CNT_W       = DDS_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             f_in_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic [CNT_W-1:0] freq_cnt_o,
   output logic [CNT_W-1:0] high_cnt_o,
   output logic             cnt_valid_o,
   output logic             timeout_o
);

   localparam int unsigned      TMR_W     = timer_width(GATE_CYCLES, ARM_TIMEOUT);
   localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 32'd1);
   localparam logic [TMR_W-1:0] ARM_LAST  = TMR_W'(ARM_TIMEOUT - 32'd1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   // Saturating increment: a full counter stays at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
      return (en && (v != CNT_MAX)) ? (v + CNT_W'(1'b1)) : v;
   endfunction

   meas_state_e      state_q,   state_d;
   logic [TMR_W-1:0] timer_q,   timer_d;
   logic [CNT_W-1:0] edge_q,    edge_d;
   logic [CNT_W-1:0] high_q,    high_d;
   logic             to_flag_q, to_flag_d;
   logic             busy_q,    busy_d;
   logic [CNT_W-1:0] freq_q,    freq_d;
   logic [CNT_W-1:0] hout_q,    hout_d;
   logic             valid_q,   valid_d;
   logic             timeout_q, timeout_d;

   logic sync_lvl_s;
   logic rise_s;

   dds_sync_edge u_sync (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (f_in_i),
      .level_o (sync_lvl_s),
      .rise_o  (rise_s)
   );

   // next-state, counter and output logic of the measurement FSM
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      edge_d    = edge_q;
      high_d    = high_q;
      to_flag_d = to_flag_q;
      busy_d    = busy_q;
      freq_d    = freq_q;
      hout_d    = hout_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d   = ARM;
               busy_d    = 1'b1;
               timeout_d = 1'b0;
               to_flag_d = 1'b0;
               edge_d    = {CNT_W{1'b0}};
               high_d    = {CNT_W{1'b0}};
               timer_d   = {TMR_W{1'b0}};
            end else begin
               busy_d = 1'b0;
            end
         end
         ARM: begin
            // The arming edge only opens the window; it is not itself counted.
            if (rise_s) begin
               state_d = GATE;
               timer_d = {TMR_W{1'b0}};
            end else if (timer_q == ARM_LAST) begin
               state_d   = DONE;
               to_flag_d = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1'b1);
            end
         end
         GATE: begin
            edge_d = sat_inc(edge_q, rise_s);
            high_d = sat_inc(high_q, sync_lvl_s);
            if (timer_q == GATE_LAST) begin
               state_d = DONE;
            end else begin
               timer_d = timer_q + TMR_W'(1'b1);
            end
         end
         DONE: begin
            freq_d    = edge_q;
            hout_d    = high_q;
            valid_d   = 1'b1;
            busy_d    = 1'b0;
            timeout_d = to_flag_q;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // state, counters and registered outputs
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         timer_q   <= {TMR_W{1'b0}};
         edge_q    <= {CNT_W{1'b0}};
         high_q    <= {CNT_W{1'b0}};
         to_flag_q <= 1'b0;
         busy_q    <= 1'b0;
         freq_q    <= {CNT_W{1'b0}};
         hout_q    <= {CNT_W{1'b0}};
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         edge_q    <= edge_d;
         high_q    <= high_d;
         to_flag_q <= to_flag_d;
         busy_q    <= busy_d;
         freq_q    <= freq_d;
         hout_q    <= hout_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign busy_o      = busy_q;
   assign freq_cnt_o  = freq_q;
   assign high_cnt_o  = hout_q;
   assign cnt_valid_o = valid_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Self-checking bench for dds_freq_meter: a 32-bit and an 8-bit instance are
// compared against a sample-stream reference model of the gated measurement.
module tb_dds_freq_meter;

   localparam int G  = 1000;
   localparam int G8 = 300;
   localparam int T  = 50;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic f_in = 1'b0;
   logic start = 1'b0;
   logic start8 = 1'b0;

   logic        busy, cnt_valid, timeout;
   logic [31:0] freq_cnt, high_cnt;
   logic        busy8, cnt_valid8, timeout8;
   logic [7:0]  freq8, high8;

   int n_cmp = 0;
   int n_bad = 0;

   logic samp [0:65535];
   int   cyc = 0;

   int wmode = 0;
   int wper = 10;
   int whi = 5;
   int wph = 0;
   int run_left = 0;

   int          r_e0, r_lat, r_np, r_vk;
   logic [31:0] r_f, r_h;
   logic        r_to, r_busy_mid, r_busy_after;
   int          m_f, m_h, m_lat;
   logic        m_to;

   dds_freq_meter #(.GATE_CYCLES(G), .ARM_TIMEOUT(T), .CNT_W(32)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .f_in_i(f_in), .start_i(start),
      .busy_o(busy), .freq_cnt_o(freq_cnt), .high_cnt_o(high_cnt),
      .cnt_valid_o(cnt_valid), .timeout_o(timeout)
   );

   dds_freq_meter #(.GATE_CYCLES(G8), .ARM_TIMEOUT(T), .CNT_W(8)) dut8 (
      .clk_i(clk), .rst_n_i(rst_n), .f_in_i(f_in), .start_i(start8),
      .busy_o(busy8), .freq_cnt_o(freq8), .high_cnt_o(high8),
      .cnt_valid_o(cnt_valid8), .timeout_o(timeout8)
   );

   always #5 clk = ~clk;

   // the value of f_in seen at every rising clock edge
   always @(posedge clk) begin
      samp[cyc] <= f_in;
      cyc       <= cyc + 1;
   end

   // waveform source: 0 = held low, 1 = periodic, other = random run lengths
   initial begin
      forever begin
         @(posedge clk); #1;
         case (wmode)
            0: f_in = 1'b0;
            1: begin
               wph  = (wph + 1) % wper;
               f_in = (wph < whi);
            end
            default: begin
               if (run_left <= 1) begin
                  f_in     = ~f_in;
                  run_left = int'($urandom_range(1, 12));
               end else begin
                  run_left = run_left - 1;
               end
            end
         endcase
      end
   end

   task automatic set_periodic(input int per, input int hi);
      wper = per; whi = hi; wph = 0; wmode = 1;
   endtask

   // Reference: find the first rising sample the armed meter can see, then
   // count rising samples and high samples in the following window.
   task automatic model(input bit sel);
      int gate, w, a, nf, nh;
      longint cap;
      gate = sel ? G8 : G;
      w    = sel ? 8 : 32;
      cap  = (longint'(1) << w) - 1;
      a    = -1;
      for (int i = r_e0 - 1; i <= r_e0 + T - 2; i++)
         if (a < 0 && samp[i] === 1'b1 && samp[i-1] === 1'b0) a = i;
      if (a < 0) begin
         m_f = 0; m_h = 0; m_to = 1'b1; m_lat = T + 1;
      end else begin
         nf = 0; nh = 0;
         for (int j = a + 1; j <= a + gate; j++) begin
            if (samp[j] === 1'b1 && samp[j-1] === 1'b0) nf++;
            if (samp[j] === 1'b1) nh++;
         end
         m_f   = (longint'(nf) > cap) ? int'(cap) : nf;
         m_h   = (longint'(nh) > cap) ? int'(cap) : nh;
         m_to  = 1'b0;
         m_lat = a + gate + 3 - r_e0;
      end
   endtask

   // pulse start on one instance and observe it until a few cycles past cnt_valid
   task automatic measure(input bit sel, input int mid_start, input int bound);
      int  k;
      bit  done;
      @(posedge clk); #1;
      if (sel) start8 = 1'b1; else start = 1'b1;
      @(posedge clk); #1;
      r_e0 = cyc - 1;
      start = 1'b0; start8 = 1'b0;
      r_np = 0; r_vk = -1; r_lat = -1; r_f = 32'd0; r_h = 32'd0; r_to = 1'b0;
      r_busy_mid = 1'b0; r_busy_after = 1'b1;
      k = 1; done = 1'b0;
      while (!done) begin
         if (k == mid_start) begin
            if (sel) start8 = 1'b1; else start = 1'b1;
         end
         @(negedge clk);
         if (k == 3) r_busy_mid = sel ? busy8 : busy;
         if ((sel ? cnt_valid8 : cnt_valid) === 1'b1) begin
            r_np++;
            if (r_vk < 0) begin
               r_vk  = k;
               r_lat = k - 1;
               r_f   = sel ? {24'd0, freq8} : freq_cnt;
               r_h   = sel ? {24'd0, high8} : high_cnt;
               r_to  = sel ? timeout8 : timeout;
            end
         end
         if (r_vk >= 0 && k == r_vk + 1) r_busy_after = sel ? busy8 : busy;
         @(posedge clk); #1;
         start = 1'b0; start8 = 1'b0;
         k++;
         if (k > bound || (r_vk >= 0 && k > r_vk + 3)) done = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_cmp++; if (freq_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_freq: got %0d expected 0", freq_cnt); end
      n_cmp++; if (high_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_high: got %0d expected 0", high_cnt); end
      n_cmp++; if (cnt_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", cnt_valid); end
      n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
      n_cmp++; if ({busy8, freq8, high8, cnt_valid8, timeout8} !== 19'd0) begin
         n_bad++; $display("FAIL rst_dut8: got %h expected 0", {busy8, freq8, high8, cnt_valid8, timeout8});
      end
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_freq_duty();
      int per [2] = '{10, 8};
      int hi  [2] = '{5, 2};
      int ef  [2] = '{100, 125};
      int eh  [2] = '{500, 250};
      for (int t = 0; t < 2; t++) begin
         set_periodic(per[t], hi[t]);
         repeat (20) @(posedge clk);
         #1;
         measure(1'b0, 0, G + T + 20);
         model(1'b0);
         n_cmp++; if (r_np !== 1) begin n_bad++; $display("FAIL fd%0d_pulses: got %0d expected 1", t, r_np); end
         n_cmp++; if (r_f !== 32'(ef[t])) begin n_bad++; $display("FAIL fd%0d_freq: got %0d expected %0d", t, r_f, ef[t]); end
         n_cmp++; if (r_h !== 32'(eh[t])) begin n_bad++; $display("FAIL fd%0d_high: got %0d expected %0d", t, r_h, eh[t]); end
         n_cmp++; if (r_f !== 32'(m_f) || r_h !== 32'(m_h)) begin
            n_bad++; $display("FAIL fd%0d_model: got %0d/%0d expected %0d/%0d", t, r_f, r_h, m_f, m_h);
         end
         n_cmp++; if (r_to !== 1'b0) begin n_bad++; $display("FAIL fd%0d_timeout: got %b expected 0", t, r_to); end
         n_cmp++; if (r_lat !== m_lat) begin n_bad++; $display("FAIL fd%0d_latency: got %0d expected %0d", t, r_lat, m_lat); end
         n_cmp++; if (r_busy_mid !== 1'b1) begin n_bad++; $display("FAIL fd%0d_busy_mid: got %b expected 1", t, r_busy_mid); end
         n_cmp++; if (r_busy_after !== 1'b0) begin n_bad++; $display("FAIL fd%0d_busy_after: got %b expected 0", t, r_busy_after); end
      end
   endtask

   task automatic test_random();
      int per;
      for (int t = 0; t < 4; t++) begin
         if (t < 2) begin
            run_left = 1; wmode = 2;
         end else begin
            per = int'($urandom_range(3, 20));
            set_periodic(per, int'($urandom_range(1, per - 1)));
         end
         repeat (int'($urandom_range(5, 30))) @(posedge clk);
         #1;
         measure(1'b0, 0, G + T + 20);
         model(1'b0);
         n_cmp++; if (r_np !== 1) begin n_bad++; $display("FAIL rnd%0d_pulses: got %0d expected 1", t, r_np); end
         n_cmp++; if (r_f !== 32'(m_f)) begin n_bad++; $display("FAIL rnd%0d_freq: got %0d expected %0d", t, r_f, m_f); end
         n_cmp++; if (r_h !== 32'(m_h)) begin n_bad++; $display("FAIL rnd%0d_high: got %0d expected %0d", t, r_h, m_h); end
         n_cmp++; if (r_to !== m_to) begin n_bad++; $display("FAIL rnd%0d_timeout: got %b expected %b", t, r_to, m_to); end
         n_cmp++; if (r_lat !== m_lat) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d expected %0d", t, r_lat, m_lat); end
      end
   endtask

   task automatic test_timeout();
      wmode = 0;
      repeat (10) @(posedge clk);
      #1;
      measure(1'b0, 0, T + 20);
      model(1'b0);
      n_cmp++; if (r_np !== 1) begin n_bad++; $display("FAIL to_pulses: got %0d expected 1", r_np); end
      n_cmp++; if (r_lat < T + 1 || r_lat > T + 2) begin n_bad++; $display("FAIL to_latency: got %0d expected %0d..%0d", r_lat, T + 1, T + 2); end
      n_cmp++; if (r_f !== 32'd0 || r_h !== 32'd0) begin n_bad++; $display("FAIL to_counts: got %0d/%0d expected 0/0", r_f, r_h); end
      n_cmp++; if (r_to !== m_to || m_to !== 1'b1) begin n_bad++; $display("FAIL to_flag: got %b expected 1", r_to); end
      set_periodic(10, 5);
      repeat (20) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b expected 1", timeout); end
      #1;
      measure(1'b0, 0, G + T + 20);
      model(1'b0);
      n_cmp++; if (r_to !== 1'b0) begin n_bad++; $display("FAIL to_cleared: got %b expected 0", r_to); end
      n_cmp++; if (r_f !== 32'd100 || r_f !== 32'(m_f)) begin n_bad++; $display("FAIL to_rerun_freq: got %0d expected 100", r_f); end
   endtask

   task automatic test_back_to_back();
      set_periodic(10, 5);
      repeat (10) @(posedge clk);
      #1;
      measure(1'b0, 300, G + T + 20);
      model(1'b0);
      n_cmp++; if (r_np !== 1) begin n_bad++; $display("FAIL b2b_pulses: got %0d expected 1", r_np); end
      n_cmp++; if (r_f !== 32'd100 || r_f !== 32'(m_f)) begin n_bad++; $display("FAIL b2b_freq1: got %0d expected 100", r_f); end
      n_cmp++; if (r_lat !== m_lat) begin n_bad++; $display("FAIL b2b_latency: got %0d expected %0d", r_lat, m_lat); end
      measure(1'b0, 0, G + T + 20);
      model(1'b0);
      n_cmp++; if (r_f !== 32'd100 || r_h !== 32'd500) begin n_bad++; $display("FAIL b2b_second: got %0d/%0d expected 100/500", r_f, r_h); end
   endtask

   task automatic test_reset_mid();
      int pulses;
      set_periodic(10, 5);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if ({busy, freq_cnt, high_cnt, cnt_valid, timeout} !== 67'd0) begin
         n_bad++; $display("FAIL rmid_outputs: got busy=%b freq=%0d high=%0d valid=%b to=%b expected all 0",
                           busy, freq_cnt, high_cnt, cnt_valid, timeout);
      end
      n_cmp++; if ({busy8, freq8, high8, cnt_valid8, timeout8} !== 19'd0) begin
         n_bad++; $display("FAIL rmid_dut8: got %h expected 0", {busy8, freq8, high8, cnt_valid8, timeout8});
      end
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 1200; k++) begin
         @(negedge clk);
         if (cnt_valid === 1'b1) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rmid_no_valid: got %0d expected 0", pulses); end
      #1;
      measure(1'b0, 0, G + T + 20);
      model(1'b0);
      n_cmp++; if (r_np !== 1 || r_f !== 32'd100 || r_h !== 32'd500) begin
         n_bad++; $display("FAIL rmid_rerun: got %0d pulses %0d/%0d expected 1 pulse 100/500", r_np, r_f, r_h);
      end
   endtask

   task automatic test_saturate();
      set_periodic(2, 1);
      repeat (10) @(posedge clk);
      #1;
      measure(1'b1, 0, G8 + T + 20);
      model(1'b1);
      n_cmp++; if (r_f !== 32'd150 || r_f !== 32'(m_f)) begin n_bad++; $display("FAIL sat_fast_freq: got %0d expected 150", r_f); end
      n_cmp++; if (r_h !== 32'(m_h)) begin n_bad++; $display("FAIL sat_fast_high: got %0d expected %0d", r_h, m_h); end
      set_periodic(10, 9);
      repeat (10) @(posedge clk);
      #1;
      measure(1'b1, 0, G8 + T + 20);
      model(1'b1);
      n_cmp++; if (r_h !== 32'd255 || r_h !== 32'(m_h)) begin n_bad++; $display("FAIL sat_high: got %0d expected 255", r_h); end
      n_cmp++; if (r_f !== 32'(m_f)) begin n_bad++; $display("FAIL sat_freq: got %0d expected %0d", r_f, m_f); end
      n_cmp++; if (r_np !== 1) begin n_bad++; $display("FAIL sat_pulses: got %0d expected 1", r_np); end
   endtask

   initial begin
      test_reset();
      test_freq_duty();
      test_random();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
